// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 key-schedule definitions: round count, round-constant table,
//   S-box table, key-generator state encoding and the 32-bit word type.
//   No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } kstate_t;

  // Round constants, indexed 1..10 (index 0 does not exist in AES).
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  // Forward AES S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant lookup that tolerates any 4-bit index; out-of-table
  // indices (0, 11..15) give zero so the mux path never reads off the table.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd1:    r = RCON[1];
      4'd2:    r = RCON[2];
      4'd3:    r = RCON[3];
      4'd4:    r = RCON[4];
      4'd5:    r = RCON[5];
      4'd6:    r = RCON[6];
      4'd7:    r = RCON[7];
      4'd8:    r = RCON[8];
      4'd9:    r = RCON[9];
      4'd10:   r = RCON[10];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
//   Combinational forward AES S-box (byte substitution).
//   Ports:
//     a  in  8  input byte
//     y  out 8  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/key_sched_word.sv
// -----------------------------------------------------------------------------
// key_sched_word
//   Combinational key-schedule word function:
//     w_out = SubWord(RotWord(w_in)) ^ {rcon, 24'h0}
//   Shared by the forward expansion step and the inverse step.
//   Ports:
//     w_in   in  32  input word (byte 0 in [31:24])
//     rcon   in  8   round constant, XORed into the top byte
//     w_out  out 32  transformed word
// -----------------------------------------------------------------------------
module key_sched_word
  import aes_pkg::*;
(
  input  logic [31:0] w_in,
  input  logic [7:0]  rcon,
  output logic [31:0] w_out
);

  word rot;
  word sub;

  // RotWord: cyclic left rotate by one byte.
  assign rot = {w_in[23:0], w_in[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*b +: 8]),
      .y (sub[8*b +: 8])
    );
  end

  assign w_out = sub ^ {rcon, 24'h000000};

endmodule

// File: rtl/inv_round_key_gen.sv
// -----------------------------------------------------------------------------
// inv_round_key_gen
//   Decrypt-side AES-128 round-key generator. A loaded cipher key is expanded
//   forward to the round-10 key, then round keys are served in descending
//   order (10 -> 0), one inverse key-schedule step per key_step pulse. Stepping
//   past round 0 reloads the stored round-10 key for the next block.
//   Ports:
//     clk        in   1    clock, rising edge
//     rst        in   1    asynchronous, active-high reset
//     key_load   in   1    pulse: capture rx_key and restart expansion
//     rx_key     in   128  cipher key, valid with key_load
//     key_step   in   1    pulse: move to the previous round's key
//     key_ready  out  1    dec_key/dec_round valid, key_step accepted
//     dec_key    out  128  round key (word 0 in [127:96])
//     dec_round  out  4    round index of dec_key
// -----------------------------------------------------------------------------
module inv_round_key_gen #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] rx_key,
  input  logic         key_step,
  output logic         key_ready,
  output logic [127:0] dec_key,
  output logic [3:0]   dec_round
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  kstate_t      state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [127:0] final_q, final_d;
  // Doubles as the expansion step counter and the served round index.
  logic [3:0]   cnt_q, cnt_d;

  word w0, w1, w2, w3;
  word sw_in, sw_out;
  logic [7:0] sw_rcon;
  word f0, f1, f2, f3;
  word i0, i1, i2, i3;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign w0 = cur_q[127:96];
  assign w1 = cur_q[95:64];
  assign w2 = cur_q[63:32];
  assign w3 = cur_q[31:0];

  // One word-function instance serves both directions: the inverse step
  // needs SubWord(RotWord(w3 ^ w2)) with rcon of the round being undone,
  // the forward step SubWord(RotWord(w3)) with rcon of the next round.
  always_comb begin
    sw_in   = w3;
    sw_rcon = rcon_at(cnt_q + 4'd1);
    if (state_q == READY) begin
      sw_in   = w3 ^ w2;
      sw_rcon = rcon_at(cnt_q);
    end
  end

  key_sched_word u_word (
    .w_in  (sw_in),
    .rcon  (sw_rcon),
    .w_out (sw_out)
  );

  // Forward step: each new word chains on the new word before it.
  assign f0 = w0 ^ sw_out;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Inverse step: every term uses the old words.
  assign i0 = w0 ^ sw_out;
  assign i1 = w1 ^ w0;
  assign i2 = w2 ^ w1;
  assign i3 = w3 ^ w2;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    final_d = final_q;
    cnt_d   = cnt_q;
    if (key_load) begin
      // Load wins over everything, including a simultaneous key_step.
      state_d = EXPAND;
      cur_d   = rx_key;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        EXPAND: begin
          cur_d = {f0, f1, f2, f3};
          cnt_d = sat_inc(cnt_q);
          if (cnt_q == LAST_ROUND - 4'd1) begin
            final_d = {f0, f1, f2, f3};
            cnt_d   = LAST_ROUND;
            state_d = READY;
          end
        end
        READY: begin
          if (key_step) begin
            if (cnt_q == 4'd0) begin
              // Wrap for the next ciphertext block without re-expanding.
              cur_d = final_q;
              cnt_d = LAST_ROUND;
            end else begin
              cur_d = {i0, i1, i2, i3};
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      final_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      final_q <= final_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_ready = (state_q == READY);
  assign dec_key   = cur_q;
  assign dec_round = cnt_q;

endmodule
